// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for a 32-bit 4:1 mux. It drives the select pair SEL1/SEL2 and a one-hot grant.
// An owner gives up the mux by handshake, or by timeout after MAX_HOLD cycles when another source is waiting.
module mux_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] REQ,
    input  logic [3:0] REL,
    output logic [3:0] GNT,
    output logic       SEL1,
    output logic       SEL2,
    output logic       BUSY,
    output logic       PREEMPT
);

    localparam logic [0:0]       S_IDLE   = 1'b0;
    localparam logic [0:0]       S_GRANT  = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    logic [0:0]       r_state;
    logic [1:0]       r_owner;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_gnt;
    logic [1:0]       r_sel;
    logic             r_busy;
    logic             r_pre;

    logic [0:0]       w_state_nxt;
    logic [1:0]       w_owner_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_gnt_nxt;
    logic [1:0]       w_sel_nxt;
    logic             w_busy_nxt;
    logic             w_pre_nxt;

    logic             w_release;
    logic [3:0]       w_others;
    logic [2:0]       w_pick_all;
    logic [2:0]       w_pick_oth;
    logic             w_do_grant;
    logic [1:0]       w_grant_idx;

    // Returns {found, index} of the first set bit scanning upward from start, with wrap-around.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // r_owner also acts as the last-owner pointer, so scanning from r_owner+1 serves both states.
    assign w_release  = REL[r_owner] | ~REQ[r_owner];
    assign w_others   = REQ & ~(4'b0001 << r_owner);
    assign w_pick_all = rr_pick(REQ, r_owner + 2'd1);
    assign w_pick_oth = rr_pick(w_others, r_owner + 2'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_busy_nxt  = r_busy;
        w_pre_nxt   = 1'b0;
        w_do_grant  = 1'b0;
        w_grant_idx = r_owner;

        case (r_state)
            S_IDLE: begin
                if (w_pick_all[2]) begin
                    w_do_grant  = 1'b1;
                    w_grant_idx = w_pick_all[1:0];
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    if (w_pick_all[2]) begin
                        w_do_grant  = 1'b1;
                        w_grant_idx = w_pick_all[1:0];
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_gnt_nxt   = 4'b0000;
                        w_busy_nxt  = 1'b0;
                        w_cnt_nxt   = '0;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    if (w_pick_oth[2]) begin
                        w_do_grant  = 1'b1;
                        w_grant_idx = w_pick_oth[1:0];
                        w_pre_nxt   = 1'b1;
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_do_grant) begin
            w_state_nxt = S_GRANT;
            w_owner_nxt = w_grant_idx;
            w_cnt_nxt   = '0;
            w_gnt_nxt   = 4'b0001 << w_grant_idx;
            w_sel_nxt   = w_grant_idx;
            w_busy_nxt  = 1'b1;
        end
    end

    // Owner resets to 3 so that source 0 has first priority after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_owner <= 2'd3;
            r_cnt   <= '0;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'b00;
            r_busy  <= 1'b0;
            r_pre   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_busy  <= w_busy_nxt;
            r_pre   <= w_pre_nxt;
        end
    end

    assign GNT     = r_gnt;
    assign SEL1    = r_sel[1];
    assign SEL2    = r_sel[0];
    assign BUSY    = r_busy;
    assign PREEMPT = r_pre;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter. A reference model predicts each edge, and a monitor checks
// the grant, select, busy and preempt outputs against that prediction.
module tb_mux_rr_arbiter;

    localparam int unsigned MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] REQ;
    logic [3:0] REL;
    logic [3:0] GNT;
    logic       SEL1;
    logic       SEL2;
    logic       BUSY;
    logic       PREEMPT;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected {GNT, SEL1, SEL2, BUSY, PREEMPT} per clock edge
    logic [7:0] exp_q[$];

    // Model state: m_owner is -1 when idle; m_held counts the cycles the current owner has held the grant.
    int m_owner;
    int m_last;
    int m_held;
    int m_sel;
    bit m_pre;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .REQ(REQ), .REL(REL),
        .GNT(GNT), .SEL1(SEL1), .SEL2(SEL2), .BUSY(BUSY), .PREEMPT(PREEMPT)
    );

    function automatic int pick(input logic [3:0] req, input int start);
        for (int k = 0; k < 4; k++) begin
            if (req[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 3;
        m_held  = 0;
        m_sel   = 0;
        m_pre   = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] req, input logic [3:0] rel);
        int         nw;
        logic [3:0] oth;
        m_pre = 1'b0;
        if (m_owner < 0) begin
            nw = pick(req, m_last + 1);
            if (nw >= 0) begin
                m_owner = nw;
                m_held  = 1;
            end
        end else if (rel[m_owner] || !req[m_owner]) begin
            nw = pick(req, m_owner + 1);
            if (nw < 0) begin
                m_last  = m_owner;
                m_owner = -1;
            end else begin
                m_owner = nw;
                m_held  = 1;
            end
        end else if (m_held == MAX_HOLD) begin
            oth          = req;
            oth[m_owner] = 1'b0;
            nw = pick(oth, m_owner + 1);
            if (nw >= 0) begin
                m_owner = nw;
                m_pre   = 1'b1;
            end
            m_held = 1;
        end else begin
            m_held++;
        end
        if (m_owner >= 0) begin
            m_last = m_owner;
            m_sel  = m_owner;
        end
    endtask

    function automatic logic [7:0] exp_vec();
        logic [3:0] g;
        g = 4'b0000;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return {g, 2'(m_sel), (m_owner >= 0), m_pre};
    endfunction

    // Drive one cycle of stimulus; the expectation is queued once the edge has happened.
    task automatic step(input logic [3:0] req, input logic [3:0] rel);
        logic [7:0] e;
        @(negedge clk);
        REQ = req;
        REL = rel;
        model_edge(req, rel);
        e = exp_vec();
        @(posedge clk);
        exp_q.push_back(e);
    endtask

    task automatic check_reset(input string name);
        n_checks++;
        if ({GNT, SEL1, SEL2, BUSY, PREEMPT} !== 8'h00) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b sel=%b%b busy=%b pre=%b, expected all zero",
                     name, GNT, SEL1, SEL2, BUSY, PREEMPT);
        end
    endtask

    // Assert reset between clock edges and confirm the outputs clear before the next edge.
    task automatic reset_mid();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset("async_reset");
        model_reset();
        REQ = 4'b0000;
        REL = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor
    initial begin
        logic [7:0] e;
        logic [7:0] got;
        forever begin
            @(negedge clk);
            got = {GNT, SEL1, SEL2, BUSY, PREEMPT};
            n_checks++;
            if (!$onehot0(GNT)) begin
                n_fail++;
                $display("FAIL gnt_onehot t=%0t: gnt=%b is neither zero nor one-hot", $time, GNT);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t: got gnt=%b sel=%b busy=%b pre=%b, expected gnt=%b sel=%b busy=%b pre=%b",
                             $time, got[7:4], got[3:2], got[1], got[0], e[7:4], e[3:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        logic [3:0] req;
        logic [3:0] rel;
        rst = 1'b1;
        REQ = 4'b0000;
        REL = 4'b0000;
        model_reset();
        #2;
        check_reset("reset_state");
        @(negedge clk);
        rst = 1'b0;

        // Single request, then drop: grant and select, then idle with SEL held at 10.
        step(4'b0100, 4'b0000);
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);

        // Async reset while source 2 holds the grant.
        step(4'b0100, 4'b0000);
        step(4'b0100, 4'b0000);
        reset_mid();

        // All four sources request; the owner pulses REL one cycle after each grant.
        step(4'b1111, 4'b0000);
        for (int i = 0; i < 6; i++) begin
            step(4'b1111, 4'b0000);
            step(4'b1111, 4'b0001 << m_owner);
        end

        // Two sources and no release: the grant rotates by timeout.
        reset_mid();
        for (int i = 0; i < 50; i++) step(4'b0011, 4'b0000);

        // A lone requester is never preempted.
        reset_mid();
        for (int i = 0; i < 40; i++) step(4'b1000, 4'b0000);

        // Release on the same edge as the timeout counts as a release; REL on a non-owner is ignored.
        reset_mid();
        step(4'b0010, 4'b0000);
        for (int i = 0; i < 15; i++) step(4'b0010, (i % 4 == 1) ? 4'b1000 : 4'b0000);
        step(4'b0111, 4'b0010);
        for (int i = 0; i < 4; i++) step(4'b0111, 4'b1000);

        // Random traffic: requests are held for stretches so that timeouts occur.
        reset_mid();
        req = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 2) req = 4'($urandom);
            rel = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            step(req, rel);
            if (i % 1000 == 999) reset_mid();
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
